// File: rtl/membus_march_checker.sv
// membus march checker: writes a seeded address pattern to every word, then
// reads each word back and reports the mismatch count and first failing address.
module membus_march_checker #(
    parameter int unsigned LEN = 256,
    parameter int unsigned DW  = 8,
    localparam int unsigned AW = $clog2(LEN),
    localparam int unsigned CW = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] d,
    output logic          wr,
    input  logic [DW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic [AW-1:0] first_err_addr
);

    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] d_q, d_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] seed_q, seed_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] exp_d1_q, exp_d1_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          err_flag_q, err_flag_d;
    logic [AW-1:0] first_q, first_d;
    logic [AW-1:0] next_addr_c;

    assign next_addr_c = addr_q + AW'(1);

    // Next-state, datapath and compare logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        d_d        = d_q;
        wr_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        seed_d     = seed_q;
        rd_valid_d = 1'b0;
        exp_d1_d   = exp_d1_q;
        raddr_d    = raddr_q;
        err_cnt_d  = err_cnt_q;
        first_d    = first_q;

        // q belongs to the address registered in the previous READ cycle
        if (rd_valid_q && (q != exp_d1_q)) begin
            err_cnt_d = err_cnt_q + CW'(1);
            if (err_cnt_q == '0) begin
                first_d = raddr_q;
            end
        end
        err_flag_d = (err_cnt_d != '0);

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                d_d    = '0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_WRITE;
                    seed_d     = seed;
                    err_cnt_d  = '0;
                    err_flag_d = 1'b0;
                    first_d    = '0;
                    busy_d     = 1'b1;
                    wr_d       = 1'b1;
                    d_d        = seed;
                end
            end
            S_WRITE: begin
                wr_d   = 1'b1;
                addr_d = next_addr_c;
                d_d    = DW'(next_addr_c) ^ seed_q;
                if (addr_q == LAST) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    wr_d    = 1'b0;
                    d_d     = '0;
                end
            end
            S_READ: begin
                rd_valid_d = 1'b1;
                exp_d1_d   = DW'(addr_q) ^ seed_q;
                raddr_d    = addr_q;
                addr_d     = next_addr_c;
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            d_q        <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seed_q     <= '0;
            rd_valid_q <= 1'b0;
            exp_d1_q   <= '0;
            raddr_q    <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            first_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            d_q        <= d_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seed_q     <= seed_d;
            rd_valid_q <= rd_valid_d;
            exp_d1_q   <= exp_d1_d;
            raddr_q    <= raddr_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            first_q    <= first_d;
        end
    end

    assign addr           = addr_q;
    assign d              = d_q;
    assign wr             = wr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign err_flag       = err_flag_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_membus_march_checker.sv
// Bench for membus_march_checker: behavioural membus memory with fault
// injection on the read path, scoreboard of write words and run results.
module tb_membus_march_checker;

    localparam int unsigned LEN = 64;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 6;
    localparam int unsigned CW  = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic          wr;
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    logic [AW-1:0] first_err_addr;

    membus_march_checker #(.LEN(LEN), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .seed           (seed),
        .addr           (addr),
        .d              (d),
        .wr             (wr),
        .q              (q),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .err_flag       (err_flag),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // Memory slave with registered read and optional read-path corruption
    logic [DW-1:0] mem [LEN];
    logic [DW-1:0] q_raw = '0;
    logic [AW-1:0] q_addr = '0;
    int            fault_mode = 0;

    always @(posedge clk) begin
        if (wr) mem[addr] <= d;
        q_raw  <= mem[addr];
        q_addr <= addr;
    end

    assign q = (fault_mode == 1 && q_addr == AW'(5)) ? (q_raw ^ 8'h01) :
               (fault_mode == 2)                     ? (q_raw & 8'hFE) : q_raw;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [CW-1:0] cnt;
        logic [AW-1:0] first;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    int   busy_cnt = 0;
    int   wr_cnt   = 0;
    wr_t  w_pop;
    res_t r_pop;

    // Output monitor: pops write and result expectations as the DUT produces them
    always @(negedge clk) begin
        if (busy) busy_cnt = busy_cnt + 1;
        if (wr) begin
            wr_cnt = wr_cnt + 1;
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'(wr), 32'd0);
            end else begin
                w_pop = wq.pop_front();
                chk("wr_word", 32'({addr, d}), 32'({w_pop.a, w_pop.d}));
            end
        end
        if (done) begin
            if (rq.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                r_pop = rq.pop_front();
                chk("done_cycle", cyc, r_pop.cyc);
                chk("err_cnt", 32'(err_cnt), 32'(r_pop.cnt));
                chk("err_flag", 32'(err_flag), 32'(r_pop.cnt != '0));
                chk("first_err_addr", 32'(first_err_addr), 32'(r_pop.first));
                chk("busy_cycles", busy_cnt, 2 * LEN + 1);
                chk("write_count", wr_cnt, LEN);
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Starts a run at the current negedge and queues its expectations
    task automatic run(input logic [DW-1:0] s, input int mode);
        logic [CW-1:0] cnt;
        logic [AW-1:0] first;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
        res_t r;
        cnt   = '0;
        first = '0;
        fault_mode = mode;
        for (int a = 0; a < LEN; a++) begin
            e = DW'(a) ^ s;
            g = e;
            if (mode == 1 && a == 5) g = g ^ 8'h01;
            if (mode == 2) g = g & 8'hFE;
            if (g != e) begin
                if (cnt == '0) first = AW'(a);
                cnt = cnt + CW'(1);
            end
            wq.push_back('{a: AW'(a), d: e});
        end
        r.cyc   = cyc + 2 * LEN + 2;
        r.cnt   = cnt;
        r.first = first;
        rq.push_back(r);
        busy_cnt = 0;
        wr_cnt   = 0;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_err_flag", 32'(err_flag), 32'd0);
        chk("clr_first", 32'(first_err_addr), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * LEN + 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_d"}, 32'(d), 32'd0);
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        chk({tag, "_first"}, 32'(first_err_addr), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic hit;
        rst   = 1'b0;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Plain pattern, then seeded pattern
        run(8'h00, 0);
        wait_done();
        @(negedge clk);
        run(8'hA5, 0);
        wait_done();

        // Single corrupted word, then stuck-at-0 on bit 0
        @(negedge clk);
        run(8'h3C, 1);
        wait_done();
        @(negedge clk);
        run(8'h00, 2);
        wait_done();

        // Reset in the middle of the write sweep
        @(negedge clk);
        run(8'h11, 0);
        hit = 1'b0;
        for (int i = 0; i < 2 * LEN; i++) begin
            if (wr && addr == AW'(20)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reached_addr20", 32'(hit), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        rq.delete();
        check_zero("abort");
        repeat (2 * LEN + 10) @(negedge clk);
        run(8'h6B, 0);
        wait_done();

        // Start during READ is ignored; start right after done runs again
        @(negedge clk);
        run(8'h5A, 1);
        hit = 1'b0;
        for (int i = 0; i < 3 * LEN; i++) begin
            if (busy && !wr && addr == AW'(10)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("read_reached_addr10", 32'(hit), 32'd1);
        seed  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        run(8'h77, 0);
        wait_done();

        repeat (5) @(negedge clk);
        chk("queues_empty", 32'(wq.size() + rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/membus_march_checker.md
Name: membus_march_checker

Overview:
- membus master that writes a seeded data pattern to every location of a membus slave memory.
- It then reads every location back, compares each word against the expected value and reports the error count and the first failing address.
- It is the read-and-verify counterpart to the write-only address-sweep tester.
- It connects to the master side of membus through discrete signals: addr, d, wr out; q in.

Parameters:
LEN, 256, number of memory words swept; address width AW = $clog2(LEN)
DW, 8, data width
CW, $clog2(LEN+1) (localparam), error counter width

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-low reset (rst==0 at posedge resets)
start  input  1  one-cycle request to begin a run; sampled only in IDLE
seed  input  DW  pattern seed, latched when start is accepted
addr  output  AW  membus address
d  output  DW  membus write data
wr  output  1  membus write enable
q  input  DW  membus read data, valid one cycle after addr is presented
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at end of run
err_cnt  output  CW  number of mismatching words in the last run
err_flag  output  1  err_cnt != 0
first_err_addr  output  AW  address of the first mismatch in the last run; 0 if none

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst.
- All outputs are registered.
- Reset (rst==0 at posedge):
  - state=IDLE.
  - addr=0, d=0, wr=0, busy=0, done=0.
  - err_cnt=0, err_flag=0, first_err_addr=0.
  - Latched seed=0.
  - Reset mid-run aborts immediately. No done pulse. The next start begins a fresh run.
- Pattern: expected(a) = DW'(a) ^ seed_latched. Truncate or zero-extend a to DW bits.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - wr=0, addr=0, busy=0.
  - start=1 moves to WRITE on the same edge.
  - On that edge: latch seed; clear err_cnt, err_flag, first_err_addr; busy=1; addr=0; wr=1; d=expected(0).
- WRITE: one word per cycle.
  - Drive wr=1, d=expected(addr).
  - addr increments by 1 each cycle.
  - At addr==LEN-1: next state READ, addr wraps to 0, wr=0.
- READ: one address per cycle, wr=0.
  - addr increments by 1 each cycle.
  - Register rd_valid and exp_d1 = expected(addr) for compare on the following cycle.
  - At addr==LEN-1: next state DRAIN, addr returns to 0.
- Compare: on every cycle where rd_valid=1 (READ cycles 2..LEN plus DRAIN):
  - If q != exp_d1, increment err_cnt.
  - If it is the first mismatch of the run, capture first_err_addr = registered address.
  - err_flag follows err_cnt != 0 with the same registration.
- DRAIN: single cycle that performs the final compare. Next state DONE.
- DONE: single cycle.
  - done=1, busy=0.
  - err_cnt, err_flag and first_err_addr are final here and hold until the next accepted start.
  - Next state IDLE.
- Run timing:
  - start accepted at edge N.
  - WRITE occupies cycles N+1..N+LEN.
  - READ occupies N+LEN+1..N+2LEN.
  - DRAIN is N+2LEN+1.
  - done is high in N+2LEN+2.
  - busy is high for exactly 2*LEN+1 cycles.
- start while busy, in DONE or in DRAIN is ignored (not queued).
- err_cnt cannot overflow: at most LEN mismatches and CW covers LEN. No saturation logic is needed.
- The block never asserts wr outside WRITE.
- Slave read-during-write ordering is irrelevant because reads occur only after all writes complete.

Test Plan:
- LEN=64, DW=8, seed=8'h00, mem slave attached, start pulse -> addr 0..63 with wr=1 and d==addr, then 64 reads; done exactly 130 cycles after the start edge; err_cnt=0, err_flag=0, first_err_addr=0.
- Same setup, seed=8'hA5 -> write data at addr 3 is 8'hA6; err_cnt=0; busy high 129 cycles.
- Bench XORs q with 8'h01 only when the returned word belongs to addr 5 -> err_cnt=1, err_flag=1, first_err_addr=5.
- Bench forces q[0]=0 during READ, seed=0 -> err_cnt=32 (odd addresses), first_err_addr=1.
- rst=0 for one cycle at WRITE addr 20 -> all outputs zero next cycle, no done pulse; subsequent start runs clean to err_cnt=0.
- Second start pulse at READ addr 10 -> ignored; single done at the original time; results unchanged. A start in the IDLE cycle after done starts a new run and clears err_cnt.
